masked_subbytes_serial: RTL and testbench
=========================================

// Module: masked_subbytes_serial
// PURPOSE
//  Byte-serial SubBytes sequencer for the first-order masked AES core. Takes a 2-share 128-bit state,
//  streams one shared byte per cycle into the external 3-stage masked S-box (the TI S-box with guards),
//  and reassembles the shared S-box outputs into a 2-share 128-bit result.
//  Sits between the round state register (upstream) and the S-box pipeline (downstream/return path).
//  Shares are never combined. Idle S-box inputs are driven to zero, so stale share values never toggle.
// PARAMETERS
//  NBYTES    16  bytes per state; byte k = bits [8k+7:8k]
//  SBOX_LAT  3   S-box register stages: input in cycle c -> output valid in cycle c+SBOX_LAT
// PORTS
//  CLK        in   1    clock, rising edge
//  RST_N      in   1    asynchronous reset, active low
//  start      in   1    request; sampled only in IDLE
//  st0_in     in   128  state share 0
//  st1_in     in   128  state share 1
//  busy       out  1    high in FEED and DRAIN
//  done       out  1    one-cycle pulse; st*_out are valid from this cycle on
//  rnd_req    out  1    high while any S-box stage holds live data; the PRNG must advance r[27:0] each such cycle
//  sbox_in0   out  8    share 0 to S-box
//  sbox_in1   out  8    share 1 to S-box
//  sbox_out0  in   8    S-box result share 0
//  sbox_out1  in   8    S-box result share 1
//  st0_out    out  128  SubBytes result share 0
//  st1_out    out  128  SubBytes result share 1
// BEHAVIOUR
//  Reset (async assert, sync use after deassert): FSM=IDLE, counters=0, valid pipe=0, input latches=0.
//   All outputs are 0: busy, done, rnd_req, sbox_in*, st*_out.
//  FSM states: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 at an edge latches st0_in/st1_in into internal share registers, sets feed_cnt=0 and goes to FEED.
//  FEED, feed_cnt=k: sbox_in0/1 = byte k of latched share 0/1. Shift 1 into vpipe[0].
//   feed_cnt increments each cycle. After k=NBYTES-1 the FSM goes to DRAIN.
//  All states other than FEED: sbox_in0/1 = 8'h00 and shift 0 into vpipe.
//  vpipe: SBOX_LAT-bit shift register. When vpipe[SBOX_LAT-1]=1 at an edge:
//   sbox_out0/1 -> byte wr_cnt of st0_out/st1_out; wr_cnt++.
//  DRAIN: leaves for DONE at the edge on which the byte with wr_cnt=NBYTES-1 is captured.
//  DONE: done=1 for exactly one cycle, then IDLE.
//   st*_out hold their value until the next capture in a later operation.
//  Latency: start edge at t0 -> first byte on sbox_in in cycle 1.
//   Last capture at the end of cycle NBYTES+SBOX_LAT; done in cycle NBYTES+SBOX_LAT+1 (=20 for defaults).
//  busy = (FEED|DRAIN). rnd_req = (FEED) | (|vpipe).
//  start while not IDLE: ignored, no queuing. start in the DONE cycle: ignored.
//  Back-to-back: start in the first IDLE cycle after DONE is accepted.
//  Reset mid-operation: immediate abort to the reset state. Partial st*_out are cleared to 0.
//  Counters are $clog2(NBYTES)+1 bits wide and never wrap inside an operation. wr_cnt is cleared on the start edge.
//  No combinational path from any input to any output; all outputs are registered or pure state decodes.
// TESTING (bench instantiates the real 3-stage S-box; reference = unmasked AES S-box)
//  1. Zero state: st0=st1=0 and random r -> st0_out^st1_out = {16{8'h63}}; done in cycle 20 after start; busy high for cycles 1..19.
//  2. Plaintext bytes 00..0F (byte k = k) split with a random share1 -> per-byte XOR of outputs = 63,7c,77,7b,f2,6b,6f,c5,30,01,67,2b,fe,d7,ab,76.
//  3. start held high continuously -> one op per 21 cycles; the start pulses in cycles 1..20 are ignored; no double capture.
//  4. RST_N low at cycle 8 of FEED -> all outputs 0 asynchronously; after release, a fresh start gives a correct result (test 2 values).
//  5. Idle hygiene: in IDLE/DONE sbox_in0=sbox_in1=8'h00 every cycle; rnd_req falls exactly SBOX_LAT cycles after the last FEED cycle.
//  6. Stress: 1000 random states and shares -> recombined output == SubBytes(st0_in^st1_in); st0_out alone never equals the unmasked result.

Source files
------------

// File: rtl/masked_subbytes_serial_if.sv
// Port bundle for the byte-serial masked SubBytes sequencer.
// The master side is the round logic plus the S-box return path.
// The slave side is the sequencer itself.
interface masked_subbytes_serial_if #(
  parameter int NBYTES = 16
);
  // Round-state side
  logic                  start;
  logic [8*NBYTES-1:0]   st0_in;
  logic [8*NBYTES-1:0]   st1_in;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   st0_out;
  logic [8*NBYTES-1:0]   st1_out;
  // Masked S-box side
  logic                  rnd_req;
  logic [7:0]            sbox_in0;
  logic [7:0]            sbox_in1;
  logic [7:0]            sbox_out0;
  logic [7:0]            sbox_out1;

  modport master (
    output start, st0_in, st1_in, sbox_out0, sbox_out1,
    input  busy, done, rnd_req, sbox_in0, sbox_in1, st0_out, st1_out
  );

  modport slave (
    input  start, st0_in, st1_in, sbox_out0, sbox_out1,
    output busy, done, rnd_req, sbox_in0, sbox_in1, st0_out, st1_out
  );
endinterface

// File: rtl/masked_subbytes_serial.sv
// Byte-serial SubBytes sequencer for a first-order masked AES core.
// Streams one shared byte per cycle into an external pipelined masked S-box
// and reassembles the returning shares into a 2-share state. The two shares
// are never combined; the S-box inputs sit at zero whenever no byte is fed.
module masked_subbytes_serial #(
  parameter int NBYTES   = 16,
  parameter int SBOX_LAT = 3
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  masked_subbytes_serial_if.slave  bus
);

  localparam int CW = $clog2(NBYTES) + 1;
  localparam int IW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         feed_cnt;
  logic [CW-1:0]         wr_cnt;
  logic [SBOX_LAT-1:0]   vpipe;
  logic [SBOX_LAT-1:0]   vpipe_next;
  logic [8*NBYTES-1:0]   sh0;
  logic [8*NBYTES-1:0]   sh1;
  logic [8*NBYTES-1:0]   out0;
  logic [8*NBYTES-1:0]   out1;
  logic [7:0]            in0;
  logic [7:0]            in1;
  logic                  busy_r;
  logic                  done_r;
  logic                  rnd_r;
  logic                  accept;
  logic                  feed_more;
  logic                  feed_next;
  logic                  capture;
  logic                  last_capture;
  logic [IW-1:0]         next_idx;

  // Decode the events that steer the sequencer during the current cycle
  always_comb begin
    accept       = (state == S_IDLE) && bus.start;
    feed_more    = (state == S_FEED) && (feed_cnt != LAST);
    feed_next    = accept || feed_more;
    vpipe_next   = {vpipe[SBOX_LAT-2:0], (state == S_FEED)};
    capture      = vpipe[SBOX_LAT-1];
    last_capture = capture && (wr_cnt == LAST);
    next_idx     = feed_cnt[IW-1:0] + IW'(1);
  end

  // Sequencer FSM with feed/capture datapath and registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      feed_cnt <= '0;
      wr_cnt   <= '0;
      vpipe    <= '0;
      sh0      <= '0;
      sh1      <= '0;
      out0     <= '0;
      out1     <= '0;
      in0      <= '0;
      in1      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rnd_r    <= 1'b0;
    end else begin
      vpipe <= vpipe_next;
      // Randomness is needed while a byte is entering or still inside the S-box
      rnd_r <= feed_next || (|vpipe_next);

      // A byte leaving the last S-box stage lands at the next output slot
      if (capture) begin
        out0[{wr_cnt[IW-1:0], 3'b000} +: 8] <= bus.sbox_out0;
        out1[{wr_cnt[IW-1:0], 3'b000} +: 8] <= bus.sbox_out1;
        wr_cnt <= wr_cnt + CW'(1);
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sh0      <= bus.st0_in;
            sh1      <= bus.st1_in;
            feed_cnt <= '0;
            wr_cnt   <= '0;
            // Byte 0 is presented in the very first FEED cycle
            in0      <= bus.st0_in[7:0];
            in1      <= bus.st1_in[7:0];
            busy_r   <= 1'b1;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          feed_cnt <= feed_cnt + CW'(1);
          if (feed_more) begin
            in0 <= sh0[{next_idx, 3'b000} +: 8];
            in1 <= sh1[{next_idx, 3'b000} +: 8];
          end else begin
            // Park the S-box inputs at zero so no stale share toggles them
            in0   <= 8'h00;
            in1   <= 8'h00;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_capture) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rnd_req  = rnd_r;
  assign bus.sbox_in0 = in0;
  assign bus.sbox_in1 = in1;
  assign bus.st0_out  = out0;
  assign bus.st1_out  = out1;

endmodule

// File: tb/tb_masked_subbytes_serial.sv
// Self-checking bench for masked_subbytes_serial. A behavioural 3-stage masked
// S-box sits on the return path; the reference is AES SubBytes computed from
// GF(2^8) inversion and the affine map.
module tb_masked_subbytes_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   op_id = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [15:0]  pipe [0:2];
  logic [7:0]   mask_byte;
  logic         hb [0:63];
  logic         hr [0:63];
  logic [7:0]   hi0 [0:63];
  logic [7:0]   hi1 [0:63];

  localparam logic [127:0] PT2  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] EXP2 = 128'h76abd7fe2b670130c56f6bf27b777c63;

  masked_subbytes_serial_if #(.NBYTES(16)) bus ();

  masked_subbytes_serial #(.NBYTES(16), .SBOX_LAT(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Masked S-box model: 3 register stages, output freshly re-masked
  always @(posedge clk) begin
    mask_byte = 8'($urandom);
    pipe[0] <= {mask_byte, sbox_tab[bus.sbox_in0 ^ bus.sbox_in1] ^ mask_byte};
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign bus.sbox_out0 = pipe[2][15:8];
  assign bus.sbox_out1 = pipe[2][7:0];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_tab[x[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation: start at a negedge, record per-cycle status until done
  task automatic run_op(input logic [127:0] a0, input logic [127:0] a1,
                        output logic [127:0] r0, output logic [127:0] r1,
                        output int dcyc);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.st0_in = a0;
    bus.st1_in = a1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dcyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      hb[n]  = bus.busy;
      hr[n]  = bus.rnd_req;
      hi0[n] = bus.sbox_in0;
      hi1[n] = bus.sbox_in1;
      if (bus.done) begin
        dcyc = n;
        break;
      end
    end
    r0 = bus.st0_out;
    r1 = bus.st1_out;
    op_id++;
    $display("op %0d: in=%h done_cycle=%0d out=%h", op_id, a0 ^ a1, dcyc, r0 ^ r1);
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.st0_in = rand128();
    bus.st1_in = rand128();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rnd_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got busy/done/rnd=%b required 000", {bus.busy, bus.done, bus.rnd_req});
    end
    checks++;
    if ({bus.sbox_in0, bus.sbox_in1} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_sbox_in: got %h required 0000", {bus.sbox_in0, bus.sbox_in1});
    end
    checks++;
    if ({bus.st0_out, bus.st1_out} !== 256'h0) begin
      errors++;
      $display("FAIL reset_st_out: got %h required 0", {bus.st0_out, bus.st1_out});
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_state();
    logic [127:0] r0, r1, e;
    int dcyc, bad_busy, bad_rnd;
    e = {16{8'h63}};
    run_op(128'h0, 128'h0, r0, r1, dcyc);
    checks++;
    if (dcyc !== 20) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d required 20", dcyc);
    end
    checks++;
    if ((r0 ^ r1) !== e) begin
      errors++;
      $display("FAIL zero_result: got %h required %h", r0 ^ r1, e);
    end
    if (dcyc == 20) begin
      bad_busy = 0;
      bad_rnd = 0;
      for (int n = 1; n <= 19; n++) begin
        if (hb[n] !== 1'b1) bad_busy++;
        if (hr[n] !== 1'b1) bad_rnd++;
      end
      if (hb[20] !== 1'b0) bad_busy++;
      if (hr[20] !== 1'b0) bad_rnd++;
      checks++;
      if (bad_busy != 0) begin
        errors++;
        $display("FAIL zero_busy_window: got %0d wrong cycles required 0 (high 1..19, low 20)", bad_busy);
      end
      checks++;
      if (bad_rnd != 0) begin
        errors++;
        $display("FAIL zero_rnd_req_window: got %0d wrong cycles required 0 (high 1..19, low 20)", bad_rnd);
      end
    end
  endtask

  task automatic test_known_plaintext();
    logic [127:0] sh, a0, r0, r1;
    int dcyc, bad_feed, bad_idle;
    sh = rand128();
    a0 = PT2 ^ sh;
    run_op(a0, sh, r0, r1, dcyc);
    checks++;
    if (dcyc !== 20) begin
      errors++;
      $display("FAIL known_done_cycle: got %0d required 20", dcyc);
    end
    checks++;
    if ((r0 ^ r1) !== EXP2) begin
      errors++;
      $display("FAIL known_result: got %h required %h", r0 ^ r1, EXP2);
    end
    if (dcyc == 20) begin
      bad_feed = 0;
      bad_idle = 0;
      for (int k = 0; k < 16; k++) begin
        if (hi0[k+1] !== a0[8*k +: 8] || hi1[k+1] !== sh[8*k +: 8]) bad_feed++;
      end
      for (int n = 17; n <= 20; n++) begin
        if (hi0[n] !== 8'h00 || hi1[n] !== 8'h00) bad_idle++;
      end
      checks++;
      if (bad_feed != 0) begin
        errors++;
        $display("FAIL known_feed_order: got %0d misplaced bytes required 0", bad_feed);
      end
      checks++;
      if (bad_idle != 0) begin
        errors++;
        $display("FAIL known_idle_sbox_in: got %0d nonzero cycles in 17..20 required 0", bad_idle);
      end
    end
  endtask

  task automatic test_start_held();
    logic [127:0] sa, sb, ma, mb, res1, res2;
    logic d [0:41];
    logic b [0:41];
    int ndone;
    sa = rand128(); sb = rand128();
    ma = rand128(); mb = rand128();
    res1 = '0; res2 = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.st0_in = sa ^ ma;
    bus.st1_in = ma;
    @(posedge clk);
    #1;
    bus.st0_in = sb ^ mb;
    bus.st1_in = mb;
    ndone = 0;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      d[n] = bus.done;
      b[n] = bus.busy;
      if (bus.done === 1'b1) ndone++;
      if (n == 20) res1 = bus.st0_out ^ bus.st1_out;
      if (n == 41) begin
        res2 = bus.st0_out ^ bus.st1_out;
        bus.start = 1'b0;
      end
    end
    op_id++;
    $display("op %0d: held start, results %h / %h", op_id, res1, res2);
    checks++;
    if (ndone != 2 || d[20] !== 1'b1 || d[41] !== 1'b1) begin
      errors++;
      $display("FAIL held_done_pulses: got %0d pulses (c20=%b c41=%b) required 2 at cycles 20 and 41", ndone, d[20], d[41]);
    end
    checks++;
    if (b[21] !== 1'b0 || b[22] !== 1'b1) begin
      errors++;
      $display("FAIL held_restart: got busy c21=%b c22=%b required 0 then 1", b[21], b[22]);
    end
    checks++;
    if (res1 !== subbytes(sa)) begin
      errors++;
      $display("FAIL held_first_result: got %h required %h", res1, subbytes(sa));
    end
    checks++;
    if (res2 !== subbytes(sb)) begin
      errors++;
      $display("FAIL held_second_result: got %h required %h", res2, subbytes(sb));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] sh, r0, r1;
    int dcyc;
    sh = rand128();
    @(negedge clk);
    bus.start = 1'b1;
    bus.st0_in = rand128();
    bus.st1_in = rand128();
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ((bus.st0_out | bus.st1_out) === 128'h0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition: got busy=%b partial_out=%h required busy=1 and nonzero partial", bus.busy, bus.st0_out | bus.st1_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rnd_req, bus.sbox_in0, bus.sbox_in1} !== 19'h0) begin
      errors++;
      $display("FAIL midreset_status: got %h required 0", {bus.busy, bus.done, bus.rnd_req, bus.sbox_in0, bus.sbox_in1});
    end
    checks++;
    if ({bus.st0_out, bus.st1_out} !== 256'h0) begin
      errors++;
      $display("FAIL midreset_st_out: got %h required 0", {bus.st0_out, bus.st1_out});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(PT2 ^ sh, sh, r0, r1, dcyc);
    checks++;
    if (dcyc !== 20 || (r0 ^ r1) !== EXP2) begin
      errors++;
      $display("FAIL midreset_recovery: got done_cycle=%0d result=%h required 20 and %h", dcyc, r0 ^ r1, EXP2);
    end
  endtask

  task automatic test_stress();
    logic [127:0] a0, a1, r0, r1, ref_v;
    int dcyc;
    for (int i = 0; i < 1000; i++) begin
      a0 = rand128();
      a1 = rand128();
      ref_v = subbytes(a0 ^ a1);
      run_op(a0, a1, r0, r1, dcyc);
      checks++;
      if (dcyc !== 20 || (r0 ^ r1) !== ref_v) begin
        errors++;
        $display("FAIL stress_result[%0d]: got done_cycle=%0d result=%h required 20 and %h", i, dcyc, r0 ^ r1, ref_v);
      end
      checks++;
      if (r0 === ref_v) begin
        errors++;
        $display("FAIL stress_share_leak[%0d]: got st0_out=%h required different from %h", i, r0, ref_v);
      end
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.st0_in = '0;
    bus.st1_in = '0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    test_reset();
    test_zero_state();
    test_known_plaintext();
    test_start_held();
    test_reset_mid();
    test_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
